// File: rtl/exec_ctrl_stage_if.sv
// Bus bundle for exec_ctrl_stage: decode input/controls and the ID/EX -> EX/MEM path.
// The slave modport is the stage itself; the master modport is whoever drives it.
interface exec_ctrl_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned IW = 9
);
  // Decode side
  logic [IW-1:0] instruction_in;
  logic          stall;
  logic          halt_signal;
  logic          halted;
  logic          branch;
  logic          jump_sign;
  logic          move;
  logic          immediate;
  logic          write;
  logic          readMem;
  logic          writeMem;
  logic          branch_jump;
  logic [3:0]    readReg0;
  logic [3:0]    readReg1;
  logic [4:0]    write_reg;
  logic [3:0]    ALUOp;
  logic [1:0]    regToMem;
  logic [1:0]    quarter;

  // Execute side
  logic [3:0]    alu_op_ex;
  logic [DW-1:0] readData0;
  logic [DW-1:0] readData1;
  logic          ReadMem_ex;
  logic          WriteMem_ex;
  logic          write_ex;
  logic [DW-1:0] DataIn_ex;
  logic [1:0]    quarter_ex;
  logic [4:0]    writeReg_ex;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic [DW-1:0] o_DataAddress;
  logic          o_ReadMem;
  logic          o_WriteMem;
  logic          o_write;
  logic [DW-1:0] o_DataIn;
  logic [1:0]    o_quarter;
  logic [4:0]    o_writeReg;

  modport master (
    output instruction_in, stall, alu_op_ex, readData0, readData1, ReadMem_ex, WriteMem_ex,
           write_ex, DataIn_ex, quarter_ex, writeReg_ex,
    input  halt_signal, halted, branch, jump_sign, move, immediate, write, readMem, writeMem,
           branch_jump, readReg0, readReg1, write_reg, ALUOp, regToMem, quarter, alu_result,
           alu_zero, o_DataAddress, o_ReadMem, o_WriteMem, o_write, o_DataIn, o_quarter,
           o_writeReg
  );

  modport slave (
    input  instruction_in, stall, alu_op_ex, readData0, readData1, ReadMem_ex, WriteMem_ex,
           write_ex, DataIn_ex, quarter_ex, writeReg_ex,
    output halt_signal, halted, branch, jump_sign, move, immediate, write, readMem, writeMem,
           branch_jump, readReg0, readReg1, write_reg, ALUOp, regToMem, quarter, alu_result,
           alu_zero, o_DataAddress, o_ReadMem, o_WriteMem, o_write, o_DataIn, o_quarter,
           o_writeReg
  );
endinterface

// File: rtl/exec_ctrl_stage.sv
// Accumulator-CPU decode/ALU/EX-MEM stage: registered instruction decode with
// stall/halt bubbles, combinational 16-bit ALU, and the EX/MEM pipeline register.
// Define ALU_MUL_EN to give ALUOp 1101 an unsigned low-half multiply; otherwise it yields 0.
module exec_ctrl_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned IW = 9
) (
  input logic                clk,
  input logic                reset,
  exec_ctrl_stage_if.slave   bus
);

  localparam logic [3:0] OpHalt   = 4'b0000;
  localparam logic [3:0] OpLoad   = 4'b1000;
  localparam logic [3:0] OpStore  = 4'b1001;
  localparam logic [3:0] OpMove   = 4'b1010;
  localparam logic [3:0] OpImm    = 4'b1011;
  localparam logic [3:0] OpBranch = 4'b1100;

  logic [IW-1:0] instr;
  logic [3:0]    op;
  logic [3:0]    r;
  assign instr = bus.instruction_in;
  assign op    = instr[8:5];
  assign r     = instr[3:0];

  // Next-state decode controls
  logic       halt_d, branch_d, jump_sign_d, move_d, immediate_d, write_d, read_mem_d;
  logic       write_mem_d;
  logic [3:0] read_reg0_d, read_reg1_d, alu_op_d;
  logic [4:0] write_reg_d;
  logic [1:0] reg_to_mem_d, quarter_d;
  logic       bubble;

  assign bubble          = bus.stall | bus.halted;
  assign bus.branch_jump = (op == OpBranch);

  // Decode the fetched instruction into control values
  always_comb begin
    halt_d       = 1'b0;
    branch_d     = 1'b0;
    jump_sign_d  = 1'b0;
    move_d       = 1'b0;
    immediate_d  = 1'b0;
    write_d      = 1'b0;
    read_mem_d   = 1'b0;
    write_mem_d  = 1'b0;
    read_reg0_d  = 4'd0;
    read_reg1_d  = 4'd0;
    write_reg_d  = 5'd0;
    alu_op_d     = 4'b0000;
    reg_to_mem_d = 2'b00;
    quarter_d    = 2'b00;
    case (op)
      OpHalt: halt_d = 1'b1;
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
        alu_op_d    = op;
        read_reg1_d = r;
        write_d     = 1'b1;
      end
      OpLoad: begin
        read_reg1_d = r;
        alu_op_d    = 4'b1011;
        read_mem_d  = 1'b1;
        write_d     = 1'b1;
      end
      OpStore: begin
        read_reg1_d = r;
        alu_op_d    = 4'b1011;
        write_mem_d = 1'b1;
      end
      OpMove: begin
        move_d      = 1'b1;
        write_d     = 1'b1;
        write_reg_d = {1'b0, r};
      end
      OpImm: begin
        immediate_d = 1'b1;
        quarter_d   = instr[4:3];
        read_reg0_d = {1'b0, instr[2:0]};
        write_d     = 1'b1;
      end
      OpBranch: begin
        branch_d    = 1'b1;
        jump_sign_d = instr[4];
        read_reg0_d = r;
        alu_op_d    = 4'b1100;
      end
      default: ;
    endcase
  end

  // IF/ID control latch; a bubble (stall or halted) loads all-zero controls
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      bus.halt_signal <= 1'b0;
      bus.branch      <= 1'b0;
      bus.jump_sign   <= 1'b0;
      bus.move        <= 1'b0;
      bus.immediate   <= 1'b0;
      bus.write       <= 1'b0;
      bus.readMem     <= 1'b0;
      bus.writeMem    <= 1'b0;
      bus.readReg0    <= 4'd0;
      bus.readReg1    <= 4'd0;
      bus.write_reg   <= 5'd0;
      bus.ALUOp       <= 4'd0;
      bus.regToMem    <= 2'd0;
      bus.quarter     <= 2'd0;
    end else begin
      bus.halt_signal <= halt_d;
      bus.branch      <= branch_d;
      bus.jump_sign   <= jump_sign_d;
      bus.move        <= move_d;
      bus.immediate   <= immediate_d;
      bus.write       <= write_d;
      bus.readMem     <= read_mem_d;
      bus.writeMem    <= write_mem_d;
      bus.readReg0    <= read_reg0_d;
      bus.readReg1    <= read_reg1_d;
      bus.write_reg   <= write_reg_d;
      bus.ALUOp       <= alu_op_d;
      bus.regToMem    <= reg_to_mem_d;
      bus.quarter     <= quarter_d;
    end
  end

  // Sticky halt: only a HALT that actually gets latched (no bubble) sets it
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.halted <= 1'b0;
    end else if (!bubble && halt_d) begin
      bus.halted <= 1'b1;
    end
  end

  logic [DW-1:0] a, b, res;
  assign a = bus.readData0;
  assign b = bus.readData1;

  // Combinational ALU, all results wrap to DW bits
  always_comb begin
    res = '0;
    case (bus.alu_op_ex)
      4'b0000: res = a;
      4'b0001: res = a + b;
      4'b0010: res = a - b;
      4'b0011: res = a & b;
      4'b0100: res = a | b;
      4'b0101: res = a ^ b;
      4'b0110: res = ~a;
      4'b0111: res = a << b[3:0];
      4'b1000: res = a >> b[3:0];
      4'b1001: res = $unsigned($signed(a) >>> b[3:0]);
      4'b1010: res = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1011: res = b;
      4'b1100: res = {{(DW-1){1'b0}}, (a == b)};
`ifdef ALU_MUL_EN
      4'b1101: res = a * b;
`else
      4'b1101: res = '0;
`endif
      default: res = '0;
    endcase
  end

  assign bus.alu_result = res;
  assign bus.alu_zero   = (res == '0);

  // EX/MEM register; upstream bubbles already arrive as zeros, so no enable
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.o_DataAddress <= '0;
      bus.o_ReadMem     <= 1'b0;
      bus.o_WriteMem    <= 1'b0;
      bus.o_write       <= 1'b0;
      bus.o_DataIn      <= '0;
      bus.o_quarter     <= 2'd0;
      bus.o_writeReg    <= 5'd0;
    end else begin
      bus.o_DataAddress <= res;
      bus.o_ReadMem     <= bus.ReadMem_ex;
      bus.o_WriteMem    <= bus.WriteMem_ex;
      bus.o_write       <= bus.write_ex;
      bus.o_DataIn      <= bus.DataIn_ex;
      bus.o_quarter     <= bus.quarter_ex;
      bus.o_writeReg    <= bus.writeReg_ex;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_stage.sv
// Bench for exec_ctrl_stage: directed vectors, a cycle-level reference model and
// literal expectations pinning the test-plan cases.
module tb_exec_ctrl_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_ctrl_stage_if bus ();
  exec_ctrl_stage dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       halt_signal, branch, jump_sign, move, immediate, write, readMem, writeMem;
    logic [3:0] rr0, rr1;
    logic [4:0] wr;
    logic [3:0] aluop;
    logic [1:0] r2m, quarter;
  } ctrl_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        rd, wm, wr;
    logic [15:0] din;
    logic [1:0]  q;
    logic [4:0]  wreg;
  } exmem_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference decode, straight from the opcode table
  function automatic ctrl_t decode(input logic [8:0] ins);
    ctrl_t c = '0;
    int op = int'(ins[8:5]);
    logic [3:0] r = ins[3:0];
    if (op == 0) c.halt_signal = 1'b1;
    else if (op <= 7) begin c.aluop = ins[8:5]; c.rr1 = r; c.write = 1'b1; end
    else if (op == 8) begin c.rr1 = r; c.aluop = 4'd11; c.readMem = 1'b1; c.write = 1'b1; end
    else if (op == 9) begin c.rr1 = r; c.aluop = 4'd11; c.writeMem = 1'b1; end
    else if (op == 10) begin c.move = 1'b1; c.write = 1'b1; c.wr = {1'b0, r}; end
    else if (op == 11) begin
      c.immediate = 1'b1; c.quarter = ins[4:3]; c.rr0 = {1'b0, ins[2:0]}; c.write = 1'b1;
    end else if (op == 12) begin
      c.branch = 1'b1; c.jump_sign = ins[4]; c.rr0 = r; c.aluop = 4'd12;
    end
    return c;
  endfunction

  // Reference ALU using integer arithmetic
  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a16,
                                      input logic [15:0] b16);
    int a = int'(a16);
    int b = int'(b16);
    int sa = (a >= 32768) ? a - 65536 : a;
    int sb = (b >= 32768) ? b - 65536 : b;
    int sh = b % 16;
    int r;
    case (int'(op))
      0: r = a;
      1: r = a + b;
      2: r = a - b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 65535 - a;
      7: r = a * (1 << sh);
      8: r = a / (1 << sh);
      9: r = sa >>> sh;
      10: r = (sa < sb) ? 1 : 0;
      11: r = b;
      12: r = (a == b) ? 1 : 0;
`ifdef ALU_MUL_EN
      13: r = int'((longint'(a) * longint'(b)) % 65536);
`else
      13: r = 0;
`endif
      default: r = 0;
    endcase
    return 16'(r & 65535);
  endfunction

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c = '{bus.halt_signal, bus.branch, bus.jump_sign, bus.move, bus.immediate, bus.write,
          bus.readMem, bus.writeMem, bus.readReg0, bus.readReg1, bus.write_reg, bus.ALUOp,
          bus.regToMem, bus.quarter};
    return c;
  endfunction

  function automatic exmem_t dut_ex();
    exmem_t e;
    e = '{bus.o_DataAddress, bus.o_ReadMem, bus.o_WriteMem, bus.o_write, bus.o_DataIn,
          bus.o_quarter, bus.o_writeReg};
    return e;
  endfunction

  // Model state, advanced on each rising edge from the inputs seen before it
  ctrl_t  m_ctrl;
  exmem_t m_ex;
  logic   m_halted;
  logic   m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_ctrl = '0; m_ex = '0; m_halted = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      logic bub;
      ctrl_t nc;
      bub = bus.stall || m_halted;
      nc  = bub ? ctrl_t'('0) : decode(bus.instruction_in);
      if (nc.halt_signal) m_halted = 1'b1;
      m_ctrl = nc;
      m_ex = '{alu(bus.alu_op_ex, bus.readData0, bus.readData1), bus.ReadMem_ex,
               bus.WriteMem_ex, bus.write_ex, bus.DataIn_ex, bus.quarter_ex, bus.writeReg_ex};
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      logic [15:0] er;
      er = alu(bus.alu_op_ex, bus.readData0, bus.readData1);
      chk("ctrl", 64'(dut_ctrl()), 64'(m_ctrl));
      chk("halted", 64'(bus.halted), 64'(m_halted));
      chk("branch_jump", 64'(bus.branch_jump), 64'(bus.instruction_in[8:5] == 4'd12));
      chk("alu_result", 64'(bus.alu_result), 64'(er));
      chk("alu_zero", 64'(bus.alu_zero), 64'(er == 16'd0));
      chk("exmem", 64'(dut_ex()), 64'(m_ex));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.alu_op_ex = op; bus.readData0 = a; bus.readData1 = b;
  endtask

  initial begin
    reset = 1'b1;
    bus.instruction_in = 9'h020;
    bus.stall = 1'b0;
    set_alu(4'd0, 16'd0, 16'd0);
    bus.ReadMem_ex = 1'b0; bus.WriteMem_ex = 1'b0; bus.write_ex = 1'b0;
    bus.DataIn_ex = 16'd0; bus.quarter_ex = 2'd0; bus.writeReg_ex = 5'd0;

    tick(); tick();
    chk("reset_ctrl", 64'(dut_ctrl()), 64'd0);
    chk("reset_exmem", 64'(dut_ex()), 64'd0);
    chk("reset_halted", 64'(bus.halted), 64'd0);

    reset = 1'b0;
    tick();
    chk("add_decode", {bus.write, bus.ALUOp}, {1'b1, 4'b0001});

    bus.instruction_in = 9'b1100_1_0101;
    #1 chk("branch_comb", 64'(bus.branch_jump), 64'd1);
    tick();
    chk("branch_reg", {bus.branch, bus.jump_sign, bus.readReg0, bus.ALUOp},
        {1'b1, 1'b1, 4'd5, 4'b1100});

    bus.instruction_in = 9'b1000_0_0011;
    bus.stall = 1'b1;
    tick();
    chk("stall_bubble", 64'(dut_ctrl()), 64'd0);
    bus.stall = 1'b0;
    tick();
    chk("load_decode", {bus.readMem, bus.write, bus.ALUOp, bus.readReg1},
        {1'b1, 1'b1, 4'b1011, 4'd3});

    bus.instruction_in = 9'b1011_10_101;
    tick();
    chk("imm_decode", {bus.immediate, bus.quarter, bus.readReg0, bus.write},
        {1'b1, 2'd2, 4'd5, 1'b1});
    bus.instruction_in = 9'b1010_0_0111;
    tick();
    chk("move_decode", {bus.move, bus.write_reg, bus.write}, {1'b1, 5'd7, 1'b1});

    // HALT under stall must not latch
    bus.instruction_in = 9'h000;
    bus.stall = 1'b1;
    tick();
    chk("halt_in_stall", {bus.halt_signal, bus.halted}, 2'b00);
    bus.stall = 1'b0;
    tick();
    chk("halt", {bus.halt_signal, bus.halted}, 2'b11);
    bus.instruction_in = 9'h020;
    tick();
    chk("after_halt", {bus.halt_signal, bus.halted, bus.write, bus.ALUOp}, {2'b01, 5'd0});
    tick();
    chk("halt_sticky", 64'(bus.halted), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_cleared", 64'(bus.halted), 64'd0);

    // Sweep non-halt opcodes; the per-cycle compare covers them
    for (int op = 1; op < 16; op++) begin
      bus.instruction_in = {4'(op), 5'b1_0110};
      tick();
    end

    // ALU boundary literals
    set_alu(4'd2, 16'h8000, 16'd1);
    #1 chk("sub", 64'(bus.alu_result), 64'h7FFF);
    set_alu(4'd9, 16'h8000, 16'd4);
    #1 chk("sra", 64'(bus.alu_result), 64'hF800);
    set_alu(4'd10, 16'h8000, 16'd1);
    #1 chk("slt", 64'(bus.alu_result), 64'd1);
    set_alu(4'd1, 16'hFFFF, 16'd1);
    #1 chk("add_wrap", {bus.alu_result, bus.alu_zero}, {16'h0000, 1'b1});
    set_alu(4'd13, 16'h0100, 16'h0100);
    #1 chk("mul_wrap", 64'(bus.alu_result), 64'd0);
    set_alu(4'd13, 16'd3, 16'd5);
`ifdef ALU_MUL_EN
    #1 chk("mul", 64'(bus.alu_result), 64'd15);
`else
    #1 chk("mul_off", 64'(bus.alu_result), 64'd0);
`endif
    tick();

    // ALU sweep over all ops with a few operand pairs
    for (int op = 0; op < 16; op++) begin
      set_alu(4'(op), 16'hA5C3, 16'h0007); tick();
      set_alu(4'(op), 16'h1234, 16'h1234); tick();
      set_alu(4'(op), 16'h7FFF, 16'hFFFE); tick();
    end

    // EX/MEM capture
    set_alu(4'd1, 16'd3, 16'd4);
    bus.ReadMem_ex = 1'b1; bus.writeReg_ex = 5'd5;
    bus.DataIn_ex = 16'hBEEF; bus.quarter_ex = 2'd3; bus.write_ex = 1'b1;
    tick();
    chk("exmem_cap", {bus.o_DataAddress, bus.o_ReadMem, bus.o_writeReg},
        {16'd7, 1'b1, 5'd5});
    chk("exmem_misc", {bus.o_DataIn, bus.o_quarter, bus.o_write, bus.o_WriteMem},
        {16'hBEEF, 2'd3, 1'b1, 1'b0});
    bus.ReadMem_ex = 1'b0; bus.WriteMem_ex = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/exec_ctrl_stage.md
Name: exec_ctrl_stage

Overview:
- Combines three pipeline pieces of the 16-bit accumulator CPU: the instruction decoder (Control_Unit), the combinational ALU, and the EX/MEM pipeline register.
- Decode side: turns a 9-bit fetched instruction into registered control for the IF/ID latch.
- Execute side: computes the ALU result from ID/EX operands and registers it with the memory/writeback controls toward RAM and MEM/WB.

Parameters:
- DW, 16, datapath width.
- IW, 9, instruction width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instruction_in  in  9  fetched instruction
- stall  in  1  hazard stall; forces a decode bubble
- halt_signal  out  1  registered: HALT decoded
- halted  out  1  sticky halt, to fetch
- branch, jump_sign, move, immediate, write, readMem, writeMem  out  1 each  registered decode controls
- branch_jump  out  1  combinational: current instruction is a branch
- readReg0, readReg1  out  4  register selects
- write_reg  out  5  destination register
- ALUOp  out  4  ALU operation
- regToMem  out  2  store-data select
- quarter  out  2  immediate quarter select
- alu_op_ex  in  4  ID/EX ALU operation
- readData0, readData1  in  16  ID/EX operands
- ReadMem_ex, WriteMem_ex, write_ex  in  1 each  ID/EX controls
- DataIn_ex  in  16  store data
- quarter_ex  in  2  ID/EX quarter
- writeReg_ex  in  5  ID/EX destination
- alu_result  out  16  combinational ALU result
- alu_zero  out  1  alu_result==0
- o_DataAddress  out  16  registered ALU result
- o_ReadMem, o_WriteMem, o_write  out  1 each  registered controls
- o_DataIn  out  16  registered store data
- o_quarter  out  2  registered quarter
- o_writeReg  out  5  registered destination

Behaviour:
- Reset: every registered output becomes 0; halted is cleared.
- Decode fields: op=instr[8:5], r=instr[3:0]. Default for every control output is 0, with ALUOp=0000.
- 0000 HALT: halt_signal=1 and halted set; halted holds at 1 until reset.
- 0001–0111 ALU op: ALUOp=op, readReg0=0, readReg1=r, write=1, write_reg=0.
- 1000 LOAD: readReg1=r, ALUOp=1011, readMem=1, write=1, write_reg=0.
- 1001 STORE: readReg1=r, ALUOp=1011, writeMem=1, regToMem=00.
- 1010 MOVE: move=1, readReg0=0, ALUOp=0000, write=1, write_reg={0,r}.
- 1011 IMM: immediate=1, quarter=instr[4:3], readReg0={0,instr[2:0]}, write=1, write_reg=0.
- 1100 BRANCH: branch=1, jump_sign=instr[4], readReg0=r, readReg1=0, ALUOp=1100; branch_jump=1 combinationally.
- 1101–1111: NOP.
- Decode latency: registered, 1 cycle.
- Bubble: if stall=1 or halted=1, the next edge loads all-zero controls; a HALT arriving during stall is not latched.
- ALU (combinational, 16-bit, wraps modulo 2^16):
  - 0000 pass A; 0001 A+B; 0010 A−B; 0011 A&B; 0100 A|B; 0101 A^B; 0110 ~A.
  - 0111 A<<B[3:0]; 1000 A>>B[3:0] (logical); 1001 arithmetic right shift by B[3:0].
  - 1010 signed A<B → 1, else 0; 1011 pass B; 1100 (A==B) → 1, else 0.
  - 1101 multiply: see Optional Feature. 1110, 1111 → 0.
- EX/MEM: every edge not in reset captures alu_result and all *_ex inputs; latency 1 cycle. There is no enable, so a bubble arrives as zeros from upstream.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: ALUOp 1101 gives the low 16 bits of A*B (unsigned).
- Undefined: 1101 gives 0 and no multiplier is synthesized.

Test Plan:
- Reset high for 2 cycles → all registered outputs 0, halted=0; hold instruction 0x020 (ADD r0,r0): after release, one edge → write=1, ALUOp=0001.
- Instruction 9'b1100_1_0101 → branch_jump=1 immediately; next edge branch=1, jump_sign=1, readReg0=5, ALUOp=1100.
- stall=1 with a LOAD → next edge all controls 0; drop stall → readMem=1, write=1, ALUOp=1011.
- HALT → halt_signal=1 and halted=1; follow with ADD → all controls 0 and halted stays 1 until reset.
- ALU with A=0x8000: SUB with B=1 → 0x7FFF; SRA with B=4 → 0xF800; SLT with B=1 → 1; ADD with A=0xFFFF, B=1 → 0x0000 and alu_zero=1.
- EX/MEM: alu_op_ex=0001, A=3, B=4, ReadMem_ex=1, writeReg_ex=5 → next edge o_DataAddress=7, o_ReadMem=1, o_writeReg=5; with ALU_MUL_EN, op 1101, A=B=0x0100 → 0x0000.
